hazard_detect_unit: RTL and testbench

- Issue-side partner of the EX-stage forwarding logic in the 5-stage MIPS32 pipeline.
- Decides when ID must stall or be flushed: load-use hazards, a busy multi-cycle multiply/divide, and taken-branch flush.
- Produces the registered hazard_a_exmem/hazard_b_exmem flags that the forwarding unit turns into select 2'b11 (load-data bypass).
- Sits between the ID decoder and the IF/ID, ID/EX pipeline registers.

---
 rtl/hazard_detect_unit_pkg.sv | 22 ++
 rtl/hazard_detect_unit_md_busy_counter.sv | 34 +++
 rtl/hazard_detect_unit.sv | 123 ++++++++++++
 tb/tb_hazard_detect_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hazard_detect_unit_pkg.sv
// Shared pipeline definitions: register address width, hazard FSM encoding, forward-select codes.
// Pure declarations, so there is no latency and no backpressure.
package hazard_detect_unit_pkg;

    localparam int DEF_REG_AW = 5;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_LOAD_STALL = 2'd1;
    localparam logic [1:0] ST_MD_WAIT    = 2'd2;

    // Operand select codes understood by the EX-stage forwarding mux
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] FWD_LOAD    = 2'b11;

    typedef struct packed {
        logic a;
        logic b;
    } src_pair_t;

endpackage

// File: rtl/hazard_detect_unit_md_busy_counter.sv
// Tracks multiply/divide unit occupancy; md_busy rises the cycle after issue and lasts MD_LATENCY cycles.
// No backpressure: the issuer only issues while md_busy is low.
module md_busy_counter #(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic md_busy,
    output logic md_done
);

    localparam int CW = $clog2(MD_LATENCY);

    logic [CW-1:0] md_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_cnt  <= '0;
            md_busy <= 1'b0;
        end else begin
            if (issue) begin
                md_cnt <= CW'(MD_LATENCY - 1);
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - CW'(1);
            end
            // Busy also covers the cycle in which the count sits at zero
            md_busy <= issue | (md_cnt != '0);
        end
    end

    assign md_done = (md_cnt == '0);

endmodule

// File: rtl/hazard_detect_unit.sv
// ID-stage hazard control: load-use and mult/div stalls, branch flush, registered load-bypass flags.
// Stall/flush outputs are combinational in the detecting cycle; hazard flags lag by one edge.
module hazard_detect_unit
    import hazard_detect_unit_pkg::*;
#(
    parameter int REG_AW            = DEF_REG_AW,
    parameter int MD_LATENCY        = 32,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_is_md,
    input  logic              id_reads_hilo,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_write_back,
    input  logic              branch_taken,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic              hazard_a_exmem,
    output logic              hazard_b_exmem,
    output logic              md_busy
);

    localparam logic [1:0] LS_INIT = 2'(LOAD_STALL_CYCLES - 1);

    logic [1:0] state, state_nxt;
    logic [1:0] ls_cnt, ls_cnt_nxt;
    src_pair_t  pend, pend_nxt;
    logic       lu_a, lu_b, lu, md_conf, md_done;
    logic       stall_raw, advance, md_issue;

    assign lu_a = id_valid & id_uses_rs1 & ex_mem_read & ex_write_back
                & (ex_rd != '0) & (ex_rd == id_rs1);
    assign lu_b = id_valid & id_uses_rs2 & ex_mem_read & ex_write_back
                & (ex_rd != '0) & (ex_rd == id_rs2);
    assign lu      = lu_a | lu_b;
    assign md_conf = id_valid & (id_is_md | id_reads_hilo) & md_busy;

    // Final load-stall cycle keeps holding if an MD conflict is waiting behind it
    always_comb begin
        stall_raw = 1'b0;
        case (state)
            ST_IDLE:       stall_raw = lu | md_conf;
            ST_LOAD_STALL: stall_raw = (ls_cnt != 2'd0) | md_conf;
            ST_MD_WAIT:    stall_raw = !md_done;
            default:       stall_raw = 1'b0;
        endcase
    end

    assign advance     = !stall_raw & !branch_taken;
    assign md_issue    = id_valid & id_is_md & !md_busy & advance;

    assign stall_pc    = rst & stall_raw & !branch_taken;
    assign stall_ifid  = stall_pc;
    assign bubble_idex = rst & (stall_raw | branch_taken);
    assign flush_ifid  = rst & branch_taken;

    always_comb begin
        state_nxt  = state;
        ls_cnt_nxt = ls_cnt;
        pend_nxt   = advance ? '0 : pend;
        if (branch_taken) begin
            state_nxt  = ST_IDLE;
            ls_cnt_nxt = 2'd0;
            pend_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lu) begin
                        state_nxt  = ST_LOAD_STALL;
                        ls_cnt_nxt = LS_INIT;
                        pend_nxt   = '{a: lu_a, b: lu_b};
                    end else if (md_conf) begin
                        state_nxt = ST_MD_WAIT;
                    end
                end
                ST_LOAD_STALL: begin
                    if (ls_cnt == 2'd0) state_nxt = ST_IDLE;
                    else                ls_cnt_nxt = ls_cnt - 2'd1;
                end
                ST_MD_WAIT: begin
                    if (md_done) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            ls_cnt         <= 2'd0;
            pend           <= '0;
            hazard_a_exmem <= 1'b0;
            hazard_b_exmem <= 1'b0;
        end else begin
            state          <= state_nxt;
            ls_cnt         <= ls_cnt_nxt;
            pend           <= pend_nxt;
            hazard_a_exmem <= pend.a & advance;
            hazard_b_exmem <= pend.b & advance;
        end
    end

    md_busy_counter #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy_counter (
        .clk     (clk),
        .rst     (rst),
        .issue   (md_issue),
        .md_busy (md_busy),
        .md_done (md_done)
    );

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed table-driven bench for hazard_detect_unit plus hand sequences for reset and stall-length corners.
// Second instance uses a long MD latency and a 2-bubble load stall.
module tb_hazard_detect_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_is_md, id_reads_hilo;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_mem_read, ex_write_back, branch_taken;

    logic stall_pc, stall_ifid, bubble_idex, flush_ifid, hazard_a_exmem, hazard_b_exmem, md_busy;
    logic s2_stall_pc, s2_stall_ifid, s2_bubble_idex, s2_flush_ifid;
    logic s2_hazard_a_exmem, s2_hazard_b_exmem, s2_md_busy;

    logic [6:0] obs, obs2;
    assign obs  = {stall_pc, stall_ifid, flush_ifid, bubble_idex,
                   hazard_a_exmem, hazard_b_exmem, md_busy};
    assign obs2 = {s2_stall_pc, s2_stall_ifid, s2_flush_ifid, s2_bubble_idex,
                   s2_hazard_a_exmem, s2_hazard_b_exmem, s2_md_busy};

    always #5 clk = ~clk;

    hazard_detect_unit #(.REG_AW(5), .MD_LATENCY(4), .LOAD_STALL_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_md(id_is_md),
        .id_reads_hilo(id_reads_hilo), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_write_back(ex_write_back), .branch_taken(branch_taken),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
        .flush_ifid(flush_ifid), .hazard_a_exmem(hazard_a_exmem),
        .hazard_b_exmem(hazard_b_exmem), .md_busy(md_busy)
    );

    hazard_detect_unit #(.REG_AW(5), .MD_LATENCY(16), .LOAD_STALL_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_md(id_is_md),
        .id_reads_hilo(id_reads_hilo), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_write_back(ex_write_back), .branch_taken(branch_taken),
        .stall_pc(s2_stall_pc), .stall_ifid(s2_stall_ifid), .bubble_idex(s2_bubble_idex),
        .flush_ifid(s2_flush_ifid), .hazard_a_exmem(s2_hazard_a_exmem),
        .hazard_b_exmem(s2_hazard_b_exmem), .md_busy(s2_md_busy)
    );

    // exp = {stall, flush, bubble, hazard_a, hazard_b, md_busy}
    typedef struct {
        logic       vld, u1, u2, md, hilo, mr, wb, br;
        logic [4:0] rs1, rs2, rd;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];
    vec_t d2[5];
    int   applied = 0;
    int   miscompares = 0;

    function automatic vec_t mk(input int vld, input int rs1, input int rs2, input int u1,
                                input int u2, input int md, input int hilo, input int rd,
                                input int mr, input int wb, input int br, input logic [5:0] exp);
        vec_t v;
        v.vld = (vld != 0);  v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
        v.u1 = (u1 != 0);    v.u2 = (u2 != 0); v.md = (md != 0); v.hilo = (hilo != 0);
        v.rd = 5'(rd);       v.mr = (mr != 0); v.wb = (wb != 0); v.br = (br != 0);
        v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.vld; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_uses_rs1 = v.u1; id_uses_rs2 = v.u2; id_is_md = v.md; id_reads_hilo = v.hilo;
        ex_rd = v.rd; ex_mem_read = v.mr; ex_write_back = v.wb; branch_taken = v.br;
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
        applied++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got {spc,sif,flush,bub,ha,hb,busy}=%b, expected %b", name, act, req);
        end
    endtask

    initial begin
        // load-use on rs1: lw $5 in EX, add $7,$5,$6 in ID
        tbl.push_back(mk(1, 5, 6, 1, 1, 0, 0, 5, 1, 1, 0, 6'b101000));
        tbl.push_back(mk(1, 5, 6, 1, 1, 0, 0, 0, 0, 0, 0, 6'b000000));
        tbl.push_back(mk(1, 1, 2, 1, 1, 0, 0, 7, 0, 1, 0, 6'b000100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
        // load to $0, and a load whose target the ID instruction does not read
        tbl.push_back(mk(1, 0, 3, 1, 1, 0, 0, 0, 1, 1, 0, 6'b000000));
        tbl.push_back(mk(1, 4, 3, 1, 0, 0, 0, 3, 1, 1, 0, 6'b000000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
        // mult then mfhi back-to-back
        tbl.push_back(mk(1, 8, 9, 1, 1, 1, 0, 0, 0, 0, 0, 6'b000000));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b101001));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b101001));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b101001));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b000001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
        // branch taken during a load stall
        tbl.push_back(mk(1, 1, 5, 0, 1, 0, 0, 5, 1, 1, 0, 6'b101000));
        tbl.push_back(mk(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 6'b011000));
        tbl.push_back(mk(1, 2, 3, 1, 1, 0, 0, 0, 0, 0, 0, 6'b000000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
        // simultaneous lu_b and MD conflict
        tbl.push_back(mk(1, 8, 9, 1, 1, 1, 0, 0, 0, 0, 0, 6'b000000));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000001));
        tbl.push_back(mk(1, 2, 10, 1, 1, 1, 0, 10, 1, 1, 0, 6'b101001));
        tbl.push_back(mk(1, 2, 10, 1, 1, 1, 0, 0, 0, 0, 0, 6'b101001));
        tbl.push_back(mk(1, 2, 10, 1, 1, 1, 0, 0, 0, 0, 0, 6'b101001));
        tbl.push_back(mk(1, 2, 10, 1, 1, 1, 0, 0, 0, 0, 0, 6'b000000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000011));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));

        // two-bubble load stall on dut2 while its MD unit is still busy
        d2[0] = mk(1, 5, 6, 1, 1, 0, 0, 5, 1, 1, 0, 6'b101001);
        d2[1] = mk(1, 5, 6, 1, 1, 0, 0, 0, 0, 0, 0, 6'b101001);
        d2[2] = mk(1, 5, 6, 1, 1, 0, 0, 0, 0, 0, 0, 6'b000001);
        d2[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000101);
        d2[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001);

        // reset with hazard-provoking inputs: every output must stay low
        rst = 1'b0;
        drive(mk(1, 5, 5, 1, 1, 1, 1, 5, 1, 1, 1, 6'b0));
        #2;
        check("reset_outputs", obs, 7'b0);
        check("reset_outputs_dut2", obs2, 7'b0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0));
        #6 rst = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            #5;
            check($sformatf("vec%0d", i), obs, {tbl[i].exp[5], tbl[i].exp});
        end

        // clean restart, then issue a mult and reset dut2 with md_cnt at 10
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0));
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        drive(mk(1, 8, 9, 1, 1, 1, 0, 0, 0, 0, 0, 6'b0));
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0));
        repeat (5) @(posedge clk);
        #1;
        drive(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b0));
        #2;
        check("mfhi_stall_before_reset", obs2, 7'b1101001);
        rst = 1'b0;
        #1;
        check("async_reset_mid_md", obs2, 7'b0);
        check("async_reset_mid_md_dut1", obs, 7'b0);
        #2 rst = 1'b1;
        drive(mk(1, 8, 9, 1, 1, 1, 0, 0, 0, 0, 0, 6'b0));
        #1;
        check("mult_after_reset_no_stall", obs2, 7'b0);
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0));
        #5;
        check("mult_after_reset_busy", obs2, 7'b0000001);

        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            drive(d2[k]);
            #5;
            check($sformatf("lsc2_vec%0d", k), obs2, {d2[k].exp[5], d2[k].exp});
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
